// File: rtl/fetch_sequencer.sv
// Program-counter owner for a word-indexed, combinational-read instruction memory:
// streams a program in (LOAD), then fetches into a registered decode slot (RUN) until a stop.
module fetch_sequencer #(
    parameter int          DEPTH    = 64,
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    output logic          load_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_instr,
    output logic [31:0]   if_pc,
    output logic          halted,
    output logic [AW:0]   load_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [31:0]   pc;
    logic [AW-1:0] load_ptr;

    logic slot_free;
    logic beyond;
    logic begin_load;
    logic begin_run;
    logic take_redirect;
    logic fill;
    logic halt_hit;

    // Slot handshake: a word moves to decode on a rising edge where if_valid && if_ready;
    // while if_valid is high and if_ready low, if_instr/if_pc must not change.
    assign slot_free  = !if_valid || if_ready;
    assign beyond     = pc[31:2] >= DEPTH_W;
    assign imem_addr  = pc[AW+1:2];
    assign imem_waddr = load_ptr;
    assign imem_wdata = load_data;
    assign halted     = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        load_ready    = 1'b0;
        imem_we       = 1'b0;
        begin_load    = 1'b0;
        begin_run     = 1'b0;
        take_redirect = 1'b0;
        fill          = 1'b0;
        halt_hit      = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (load_en) begin
                    state_next = S_LOAD;
                    begin_load = 1'b1;
                end else if (start) begin
                    state_next = S_RUN;
                    begin_run  = 1'b1;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                imem_we    = load_valid;
                // Filling the last word ends the load; the pointer never wraps onto word 0.
                if ((load_valid && load_ptr == LAST_PTR) || !load_en) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                end else if (slot_free) begin
                    if (beyond || imem_rdata == 32'h0) begin
                        halt_hit   = 1'b1;
                        state_next = S_HALT;
                    end else begin
                        fill = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            load_ptr   <= '0;
            load_count <= '0;
            if_valid   <= 1'b0;
            if_instr   <= 32'h0;
            if_pc      <= 32'h0;
        end else begin
            if (begin_load) begin
                load_ptr   <= '0;
                load_count <= '0;
            end else if (imem_we) begin
                load_ptr   <= load_ptr + AW'(1);
                load_count <= load_count + (AW+1)'(1);
            end

            if (begin_run) begin
                pc       <= RESET_PC;
                if_valid <= 1'b0;
            end else if (take_redirect) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                if_valid <= 1'b0;
            end else if (fill) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
                pc       <= pc + 32'd4;
            end else if (halt_hit) begin
                if_valid <= 1'b0;
            end else if (state == S_HALT && if_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: load-phase vector table, hand-written run/redirect/fill/reset
// sequences, and randomized runs checked against a program-order reference model.
module tb_fetch_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = 32'h0;
    logic          load_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic          halted;
    logic [AW:0]   load_count;

    logic [31:0] mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic        mem_clear = 1'b1;
    logic [31:0] prog_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_in [$];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic          le;
        logic          lv;
        logic          st;
        logic [31:0]   ld;
        logic          exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic [AW:0]   exp_count;
    } vec_t;
    vec_t vecs [7];

    fetch_sequencer #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .load_count(load_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end
    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {load_ready, imem_we, if_valid, halted, load_count, imem_addr}, 64'h0);
        chk({tag, "_instr"}, if_instr, 64'h0);
        chk({tag, "_pc"}, if_pc, 64'h0);
    endtask

    task automatic load_prog();
        @(negedge clk);
        load_en = 1'b1;
        load_valid = 1'b0;
        for (int i = 0; i < prog_q.size(); i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data = prog_q[i];
            exp_mem[i] = prog_q[i];
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after a falling edge; records every presented slot with if_ready held high.
    task automatic run_until_halt(input string tag, input int max_cycles);
        bit done = 0;
        got_pc.delete();
        got_in.delete();
        if_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            #1;
            if (halted) begin
                done = 1;
                break;
            end
            if (if_valid) begin
                got_pc.push_back(if_pc);
                got_in.push_back(if_instr);
            end
            @(negedge clk);
        end
        if (!done) chk({tag, "_halt_timeout"}, 64'h0, 64'h1);
        chk({tag, "_count"}, got_pc.size(), exp_q.size());
        for (int i = 0; i < got_pc.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_pc%0d", tag, i), got_pc[i], exp_q[i]);
            chk($sformatf("%s_in%0d", tag, i), got_in[i], exp_mem[exp_q[i][7:2]]);
        end
        chk({tag, "_end_valid"}, if_valid, 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 6'd0, 7'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hA0A0_0001, 1'b1, 1'b1, 6'd0, 7'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 6'd1, 7'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hB0B0_0002, 1'b1, 1'b1, 6'd1, 7'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hC0C0_0003, 1'b1, 1'b1, 6'd2, 7'd2};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hD0D0_0004, 1'b0, 1'b0, 6'd3, 7'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 6'd3, 7'd3};

        // Reset and memory clear
        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        rst_n = 1'b1;

        // Load-phase vector table (includes start+load_en priority and load_en drop with a word)
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            load_en = vecs[i].le;
            load_valid = vecs[i].lv;
            start = vecs[i].st;
            load_data = vecs[i].ld;
            #1;
            chk($sformatf("vec%0d", i),
                {load_ready, imem_we, imem_waddr, load_count, halted, if_valid},
                {vecs[i].exp_ready, vecs[i].exp_we, vecs[i].exp_waddr, vecs[i].exp_count, 2'b00});
            if (vecs[i].exp_we) chk($sformatf("vec%0d_wdata", i), imem_wdata, vecs[i].ld);
        end
        @(negedge clk);
        load_en = 1'b0;
        load_valid = 1'b0;
        chk("vec_mem", {mem[0], mem[1]}, {32'hA0A0_0001, 32'hB0B0_0002});
        chk("vec_mem_tail", {mem[2], mem[3]}, {32'hC0C0_0003, 32'h0});

        // Load + run: back-to-back presentation then halt on zero word
        prog_q = '{32'h00c02283, 32'h00100093, 32'h0};
        load_prog();
        chk("t2_load_count", load_count, 64'd3);
        if_ready = 1'b1;
        start_run();
        #1 chk("t2_c0", {if_valid, halted}, 64'h0);
        @(negedge clk);
        #1 chk("t2_c1", {if_valid, if_pc, if_instr, halted}, {1'b1, 32'h0, 32'h00c02283, 1'b0});
        @(negedge clk);
        #1 chk("t2_c2", {if_valid, if_pc, if_instr, halted}, {1'b1, 32'h4, 32'h00100093, 1'b0});
        @(negedge clk);
        #1 chk("t2_c3", {if_valid, halted}, {1'b0, 1'b1});

        // Backpressure then redirect to 0x13 while pc=8
        prog_q.delete();
        for (int i = 0; i < 8; i++) prog_q.push_back(32'h0BAD_0000 + i);
        prog_q.push_back(32'h0);
        load_prog();
        if_ready = 1'b0;
        start_run();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t3_hold%0d", k), {if_valid, if_pc, if_instr, imem_addr},
                   {1'b1, 32'h0, 32'h0BAD_0000, 6'd1});
            @(negedge clk);
        end
        if_ready = 1'b1;
        #1 chk("t3_release", {if_valid, if_pc}, {1'b1, 32'h0});
        @(negedge clk);
        #1 chk("t4_pre", {if_valid, if_pc, imem_addr}, {1'b1, 32'h4, 6'd2});
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1 chk("t4_bubble", if_valid, 64'h0);
        @(negedge clk);
        exp_q = '{32'h10, 32'h14, 32'h18, 32'h1c};
        run_until_halt("t4", 50);

        // Fill all of memory from HALT; 65th word must not land anywhere
        @(negedge clk);
        load_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data = 32'h1000 + i;
            exp_mem[i] = 32'h1000 + i;
        end
        @(negedge clk);
        load_en = 1'b0;
        load_data = 32'hDEAD_BEEF;
        #1 chk("t5_full", {load_ready, imem_we, load_count}, {1'b0, 1'b0, 7'd64});
        @(negedge clk);
        load_valid = 1'b0;
        chk("t5_mem_ends", {mem[0], mem[63]}, {32'h1000, 32'h103F});
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(i * 4));
        start_run();
        run_until_halt("t5run", 200);

        // Redirect while halted has no effect
        redirect_valid = 1'b1;
        redirect_pc = 32'h24;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("t6_halt_redir%0d", k), {halted, if_valid, imem_addr}, {1'b1, 1'b0, 6'd0});
        end
        redirect_valid = 1'b0;

        // Reset in the middle of a load
        @(negedge clk);
        load_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data = 32'hA1 + i;
            exp_mem[i] = 32'hA1 + i;
        end
        @(negedge clk);
        load_valid = 1'b1;
        load_data = 32'hEEEE_EEEE;
        rst_n = 1'b0;
        #1 chk_reset_outputs("t1_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        load_en = 1'b0;
        load_valid = 1'b0;
        #1 chk_reset_outputs("t1_after");
        chk("t1_mem01", {mem[0], mem[1]}, {32'hA1, 32'hA2});
        chk("t1_mem23", {mem[2], mem[3]}, {32'hA3, 32'h1003});

        // Randomized runs against a program-order model
        for (int r = 0; r < 8; r++) begin
            int          len;
            int          redirects_left;
            bit          prev_redir;
            bit          redir;
            bit          done;
            logic [31:0] exp_pc;
            len = $urandom_range(1, 20);
            prog_q.delete();
            for (int i = 0; i < len; i++) begin
                logic [31:0] w;
                w = $urandom;
                if (w == 32'h0) w = 32'h1;
                prog_q.push_back(w);
            end
            prog_q.push_back(32'h0);
            load_prog();
            start_run();
            exp_pc = 32'h0;
            redirects_left = 3;
            prev_redir = 0;
            done = 0;
            for (int c = 0; c < 600; c++) begin
                redir = (redirects_left > 0) && !halted && ($urandom_range(0, 9) == 0);
                if_ready = ($urandom_range(0, 3) != 0);
                redirect_valid = redir;
                redirect_pc = 32'($urandom_range(0, len)) * 4 + 32'($urandom_range(0, 3));
                #1;
                if (prev_redir) chk($sformatf("rnd%0d_bubble", r), if_valid, 64'h0);
                if (halted) begin
                    chk($sformatf("rnd%0d_halt_valid", r), if_valid, 64'h0);
                    chk($sformatf("rnd%0d_halt_at", r),
                        (exp_pc[31:2] >= DEPTH) || (exp_mem[exp_pc[7:2]] == 32'h0), 64'h1);
                    done = 1;
                    break;
                end
                if (if_valid && if_ready) begin
                    chk($sformatf("rnd%0d_pc", r), if_pc, exp_pc);
                    chk($sformatf("rnd%0d_in", r), if_instr, exp_mem[exp_pc[7:2]]);
                    exp_pc = exp_pc + 32'd4;
                end
                if (redir) begin
                    exp_pc = {redirect_pc[31:2], 2'b00};
                    redirects_left--;
                end
                prev_redir = redir;
                @(negedge clk);
            end
            redirect_valid = 1'b0;
            if (!done) chk($sformatf("rnd%0d_halt_timeout", r), 64'h0, 64'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
